dmem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the single-port data memory (64 x 32-bit words, word-indexed address, combinational read, write on rising clk).
- Port 0 serves the CPU load/store stage; port 1 serves a DMA/debug master.
- Grants one requester at a time, drives the memory address, write-data and write-enable lines, and returns read data with a one-cycle acknowledge.

---
 rtl/dmem_arbiter.sv | 116 +++++++++++
 tb/tb_dmem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port data memory.
// Each access is granted, issued to the memory for one cycle and then acknowledged.
module dmem_arbiter #(
    parameter int DEPTH     = 64,
    parameter int AW        = 32,
    parameter int PRIO_MODE = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [31:0]   p0_wd,
    output logic          p0_ack,
    output logic [31:0]   p0_rd,
    output logic          p0_err,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [31:0]   p1_wd,
    output logic          p1_ack,
    output logic [31:0]   p1_rd,
    output logic          p1_err,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [31:0]   mem_wd,
    input  logic [31:0]   mem_rd,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

    state_t        state;
    logic          last_gnt;
    logic          gnt_q;
    logic          err_lat;
    logic          gnt;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [31:0]   sel_wd;
    logic          sel_oob;

    // Winner selection: on a tie, round-robin favours the port not granted last time
    always_comb begin
        gnt = 1'b0;
        if (p0_req && p1_req) begin
            gnt = (PRIO_MODE == 1) ? 1'b0 : ~last_gnt;
        end else begin
            gnt = p1_req;
        end
        sel_we   = gnt ? p1_we   : p0_we;
        sel_addr = gnt ? p1_addr : p0_addr;
        sel_wd   = gnt ? p1_wd   : p0_wd;
        sel_oob  = (sel_addr >= DEPTH_A);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            gnt_q    <= 1'b0;
            err_lat  <= 1'b0;
            mem_we   <= 1'b0;
            mem_a    <= '0;
            mem_wd   <= '0;
            p0_ack   <= 1'b0;
            p0_err   <= 1'b0;
            p0_rd    <= '0;
            p1_ack   <= 1'b0;
            p1_err   <= 1'b0;
            p1_rd    <= '0;
            busy     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        // Out-of-range accesses are neutralised here so they never touch memory
                        mem_we   <= sel_we & ~sel_oob;
                        mem_a    <= sel_oob ? '0 : sel_addr;
                        mem_wd   <= sel_wd;
                        gnt_q    <= gnt;
                        last_gnt <= gnt;
                        err_lat  <= sel_oob;
                        busy     <= 1'b1;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we <= 1'b0;
                    if (gnt_q) begin
                        p1_rd  <= err_lat ? 32'h0 : mem_rd;
                        p1_ack <= 1'b1;
                        p1_err <= err_lat;
                    end else begin
                        p0_rd  <= err_lat ? 32'h0 : mem_rd;
                        p0_ack <= 1'b1;
                        p0_err <= err_lat;
                    end
                    state <= DONE;
                end
                DONE: begin
                    p0_ack <= 1'b0;
                    p0_err <= 1'b0;
                    p1_ack <= 1'b0;
                    p1_err <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin and a fixed-priority instance, each with its own
// memory, checked every cycle against a transaction-timestamp reference model.
module tb_dmem_arbiter;

    localparam int DEPTH = 64;

    logic        clk;
    logic        reset;
    logic        init_mem;
    logic        req     [2][2];
    logic        we      [2][2];
    logic [31:0] addr    [2][2];
    logic [31:0] wd      [2][2];
    logic        ack     [2][2];
    logic        err     [2][2];
    logic [31:0] rd      [2][2];
    logic        mem_we  [2];
    logic [31:0] mem_a   [2];
    logic [31:0] mem_wd  [2];
    logic [31:0] mem_rd  [2];
    logic        busy    [2];
    logic [31:0] env_mem [2][DEPTH];

    logic [31:0] ref_mem [2][DEPTH];
    int          g       [2];
    bit          last    [2];
    bit          gport   [2];
    bit          gwe     [2];
    bit          gerr    [2];
    int          gidx    [2];
    logic [31:0] gwd     [2];
    logic [31:0] grd     [2];
    bit          exp_ack [2][2];
    bit          exp_err [2][2];
    logic [31:0] exp_rd  [2][2];
    bit          exp_we  [2];
    bit          exp_busy[2];
    logic [31:0] exp_a   [2];
    logic [31:0] exp_wd  [2];
    bit          sticky  [2][2];
    bit          ack_seen[2][2];
    int          ack_count[2][2];
    int          edge_n;
    int          vectors;
    int          miscompares;
    int          base;

    dmem_arbiter #(.DEPTH(DEPTH), .AW(32), .PRIO_MODE(0)) u_rr (
        .clk(clk), .reset(reset),
        .p0_req(req[0][0]), .p0_we(we[0][0]), .p0_addr(addr[0][0]), .p0_wd(wd[0][0]),
        .p0_ack(ack[0][0]), .p0_rd(rd[0][0]), .p0_err(err[0][0]),
        .p1_req(req[0][1]), .p1_we(we[0][1]), .p1_addr(addr[0][1]), .p1_wd(wd[0][1]),
        .p1_ack(ack[0][1]), .p1_rd(rd[0][1]), .p1_err(err[0][1]),
        .mem_we(mem_we[0]), .mem_a(mem_a[0]), .mem_wd(mem_wd[0]), .mem_rd(mem_rd[0]),
        .busy(busy[0])
    );

    dmem_arbiter #(.DEPTH(DEPTH), .AW(32), .PRIO_MODE(1)) u_fp (
        .clk(clk), .reset(reset),
        .p0_req(req[1][0]), .p0_we(we[1][0]), .p0_addr(addr[1][0]), .p0_wd(wd[1][0]),
        .p0_ack(ack[1][0]), .p0_rd(rd[1][0]), .p0_err(err[1][0]),
        .p1_req(req[1][1]), .p1_we(we[1][1]), .p1_addr(addr[1][1]), .p1_wd(wd[1][1]),
        .p1_ack(ack[1][1]), .p1_rd(rd[1][1]), .p1_err(err[1][1]),
        .mem_we(mem_we[1]), .mem_a(mem_a[1]), .mem_wd(mem_wd[1]), .mem_rd(mem_rd[1]),
        .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int m, int i);
        return 32'hA5C3_0000 ^ (32'(i) * 32'h0101_0101) ^ (32'(m) << 28);
    endfunction

    assign mem_rd[0] = env_mem[0][mem_a[0][5:0]];
    assign mem_rd[1] = env_mem[1][mem_a[1][5:0]];

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (init_mem) begin
                for (int i = 0; i < DEPTH; i++) env_mem[m][i] <= init_word(m, i);
            end else if (mem_we[m]) begin
                env_mem[m][mem_a[m][5:0]] <= mem_wd[m];
            end
        end
    end

    task automatic cmp32(string tag, logic [31:0] obs, logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic cmp1(string tag, logic obs, logic expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic modelReset();
        for (int m = 0; m < 2; m++) begin
            g[m]        = -100;
            last[m]     = 1'b1;
            exp_we[m]   = 1'b0;
            exp_busy[m] = 1'b0;
            exp_a[m]    = '0;
            exp_wd[m]   = '0;
            for (int p = 0; p < 2; p++) begin
                exp_ack[m][p] = 1'b0;
                exp_err[m][p] = 1'b0;
                exp_rd[m][p]  = '0;
            end
        end
    endtask

    // A transaction granted at edge g acks after edge g+1; arbitration reopens at edge g+3
    task automatic modelEdge(int m);
        int          w;
        logic [31:0] a;
        exp_ack[m][0] = 1'b0;
        exp_ack[m][1] = 1'b0;
        exp_err[m][0] = 1'b0;
        exp_err[m][1] = 1'b0;
        exp_we[m]     = 1'b0;
        if (edge_n == g[m] + 1) begin
            if (gwe[m] && !gerr[m]) ref_mem[m][gidx[m]] = gwd[m];
            exp_rd[m][int'(gport[m])]  = grd[m];
            exp_ack[m][int'(gport[m])] = 1'b1;
            exp_err[m][int'(gport[m])] = gerr[m];
        end
        if (edge_n >= g[m] + 3 && (req[m][0] || req[m][1])) begin
            if (req[m][0] && req[m][1]) w = (m == 1) ? 0 : (last[m] ? 0 : 1);
            else                        w = req[m][1] ? 1 : 0;
            a         = addr[m][w];
            gport[m]  = (w == 1);
            gwe[m]    = we[m][w];
            gerr[m]   = (a >= 32'(DEPTH));
            gidx[m]   = gerr[m] ? 0 : int'(a);
            grd[m]    = gerr[m] ? 32'h0 : ref_mem[m][gidx[m]];
            gwd[m]    = wd[m][w];
            exp_we[m] = gwe[m] && !gerr[m];
            exp_a[m]  = gerr[m] ? 32'h0 : a;
            exp_wd[m] = wd[m][w];
            last[m]   = (w == 1);
            g[m]      = edge_n;
        end
        exp_busy[m] = (edge_n == g[m]) || (edge_n == g[m] + 1);
    endtask

    task automatic checkOutput();
        for (int m = 0; m < 2; m++) begin
            cmp1 ($sformatf("m%0d busy", m),   busy[m],   exp_busy[m]);
            cmp1 ($sformatf("m%0d mem_we", m), mem_we[m], exp_we[m]);
            cmp32($sformatf("m%0d mem_a", m),  mem_a[m],  exp_a[m]);
            cmp32($sformatf("m%0d mem_wd", m), mem_wd[m], exp_wd[m]);
            for (int p = 0; p < 2; p++) begin
                cmp1 ($sformatf("m%0d p%0d ack", m, p), ack[m][p], exp_ack[m][p]);
                cmp1 ($sformatf("m%0d p%0d err", m, p), err[m][p], exp_err[m][p]);
                cmp32($sformatf("m%0d p%0d rd", m, p),  rd[m][p],  exp_rd[m][p]);
            end
        end
    endtask

    task automatic applyStimulus(int m, int p, logic w, logic [31:0] a, logic [31:0] d);
        req[m][p]  = 1'b1;
        we[m][p]   = w;
        addr[m][p] = a;
        wd[m][p]   = d;
    endtask

    task automatic issueBoth(int p, logic w, logic [31:0] a, logic [31:0] d);
        for (int m = 0; m < 2; m++) applyStimulus(m, p, w, a, d);
    endtask

    // One clock: model at the edge, check 1 ns later, requesters drop after their ack
    task automatic stepCycle();
        @(posedge clk);
        edge_n++;
        if (reset) begin
            for (int m = 0; m < 2; m++) modelEdge(m);
        end
        #1;
        checkOutput();
        for (int m = 0; m < 2; m++) begin
            for (int p = 0; p < 2; p++) begin
                ack_seen[m][p] = (ack[m][p] === 1'b1);
                if (ack_seen[m][p]) ack_count[m][p]++;
            end
        end
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            for (int p = 0; p < 2; p++) begin
                if (ack_seen[m][p] && !sticky[m][p]) req[m][p] = 1'b0;
            end
        end
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 7))
            0:       return 32'(DEPTH) + 32'($urandom_range(0, 4));
            1:       return $urandom | 32'h8000_0000;
            2:       return 32'(DEPTH - 1);
            default: return 32'($urandom_range(0, DEPTH - 1));
        endcase
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        edge_n      = 0;
        for (int m = 0; m < 2; m++) begin
            for (int p = 0; p < 2; p++) begin
                req[m][p]       = 1'b0;
                we[m][p]        = 1'b0;
                addr[m][p]      = '0;
                wd[m][p]        = '0;
                sticky[m][p]    = 1'b0;
                ack_seen[m][p]  = 1'b0;
                ack_count[m][p] = 0;
            end
            for (int i = 0; i < DEPTH; i++) ref_mem[m][i] = init_word(m, i);
        end
        modelReset();
        reset    = 1'b0;
        init_mem = 1'b1;
        @(negedge clk);

        // Reset held, then released with no requests
        repeat (3) stepCycle();
        reset    = 1'b1;
        init_mem = 1'b0;
        repeat (4) stepCycle();

        // Port 0 write then read of address 5
        issueBoth(0, 1'b1, 32'd5, 32'hDEAD_BEEF);
        repeat (4) stepCycle();
        issueBoth(0, 1'b0, 32'd5, 32'h0);
        repeat (4) stepCycle();
        for (int m = 0; m < 2; m++) cmp32($sformatf("m%0d readback addr5", m), rd[m][0], 32'hDEAD_BEEF);

        // Both ports requesting continuously
        for (int m = 0; m < 2; m++) begin
            sticky[m][0] = 1'b1;
            sticky[m][1] = 1'b1;
        end
        issueBoth(0, 1'b0, 32'd1, 32'h0);
        issueBoth(1, 1'b0, 32'd2, 32'h0);
        repeat (12) stepCycle();
        cmp32("rr p1 rd addr2", rd[0][1], init_word(0, 2));
        for (int m = 0; m < 2; m++) begin
            sticky[m][0] = 1'b0;
            sticky[m][1] = 1'b0;
        end
        repeat (10) stepCycle();
        cmp32("fp p1 rd addr2 after drain", rd[1][1], init_word(1, 2));

        // Port 0 held continuously: fixed priority starves port 1 until it lets go
        sticky[0][0] = 1'b1;
        sticky[1][0] = 1'b1;
        issueBoth(0, 1'b0, 32'd3, 32'h0);
        issueBoth(1, 1'b1, 32'd4, 32'h0BAD_F00D);
        base = ack_count[1][1];
        repeat (9) stepCycle();
        cmp32("fp p1 starved", 32'(ack_count[1][1] - base), 32'd0);
        sticky[0][0] = 1'b0;
        sticky[1][0] = 1'b0;
        base = ack_count[1][1];
        repeat (8) stepCycle();
        cmp32("fp p1 served after release", 32'(ack_count[1][1] - base), 32'd1);

        // Address boundaries
        issueBoth(1, 1'b1, 32'd64, 32'h1234_5678);
        repeat (5) stepCycle();
        for (int m = 0; m < 2; m++) cmp32($sformatf("m%0d oob write rd", m), rd[m][1], 32'h0);
        issueBoth(0, 1'b0, 32'hFFFF_FFC5, 32'h0);
        issueBoth(1, 1'b0, 32'd63, 32'h0);
        repeat (8) stepCycle();
        for (int m = 0; m < 2; m++) begin
            cmp32($sformatf("m%0d addr63 rd", m), rd[m][1], init_word(m, 63));
            cmp32($sformatf("m%0d high addr rd", m), rd[m][0], 32'h0);
        end

        // Reset during the ACCESS cycle of a write to address 7
        issueBoth(0, 1'b1, 32'd7, 32'hCAFE_0007);
        stepCycle();
        reset = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            cmp1($sformatf("m%0d mid-reset mem_we", m), mem_we[m], 1'b0);
            cmp1($sformatf("m%0d mid-reset busy", m),   busy[m],   1'b0);
            cmp1($sformatf("m%0d mid-reset ack", m),    ack[m][0], 1'b0);
            req[m][0] = 1'b0;
            req[m][1] = 1'b0;
        end
        modelReset();
        stepCycle();
        reset = 1'b1;
        issueBoth(0, 1'b0, 32'd7, 32'h0);
        repeat (4) stepCycle();
        for (int m = 0; m < 2; m++) cmp32($sformatf("m%0d addr7 after reset", m), rd[m][0], init_word(m, 7));

        // Random traffic
        repeat (500) begin
            for (int m = 0; m < 2; m++) begin
                for (int p = 0; p < 2; p++) begin
                    if (!req[m][p] && !ack_seen[m][p] && $urandom_range(0, 3) == 0)
                        applyStimulus(m, p, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
                end
            end
            stepCycle();
        end
        repeat (12) stepCycle();

        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < DEPTH; i++)
                cmp32($sformatf("m%0d mem[%0d]", m, i), env_mem[m][i], ref_mem[m][i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
